// File: rtl/aemb3_mt_pcu.sv
// Multi-threaded fetch / programme-counter unit: one PC per hardware thread,
// round-robin instruction fetch, per-thread branch redirects and hazard rewinds.
module aemb3_mt_pcu #(
    parameter int IWB = 32,
    parameter int TW = 1,
    parameter logic [IWB-3:0] RST_VEC = '0
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             ena_i,
    output logic [IWB-3:0]                   iwb_adr_o,
    output logic                             iwb_stb_o,
    input  logic                             iwb_ack_i,
    input  logic [31:0]                      iwb_dat_i,
    output logic [31:0]                      ins_dat_o,
    output logic                             ins_vld_o,
    output logic [((TW > 0) ? TW : 1)-1:0]   ins_tid_o,
    output logic [IWB-3:0]                   ins_pc_o,
    input  logic                             brq_i,
    input  logic [((TW > 0) ? TW : 1)-1:0]   brq_tid_i,
    input  logic [IWB-3:0]                   brq_tgt_i,
    input  logic                             brq_dly_i,
    input  logic                             hzd_i,
    input  logic [((TW > 0) ? TW : 1)-1:0]   hzd_tid_i,
    input  logic [IWB-3:0]                   hzd_pc_i
);

    localparam int AW = IWB - 2;
    localparam int TIDW = (TW > 0) ? TW : 1;
    localparam int THREADS = 1 << TW;

    typedef enum logic {
        ST_RST,
        ST_FETCH
    } state_t;

    state_t          state;
    logic [TIDW-1:0] tid;
    logic [AW-1:0]   adr;
    logic            redir;

    logic [AW-1:0]   pc   [THREADS];
    logic            pvld [THREADS];
    logic            parm [THREADS];
    logic [AW-1:0]   ptgt [THREADS];

    logic [AW-1:0]   pc_n   [THREADS];
    logic            pvld_n [THREADS];
    logic            parm_n [THREADS];
    logic [AW-1:0]   ptgt_n [THREADS];

    logic [31:0]     ins_dat;
    logic            ins_vld;
    logic [TIDW-1:0] ins_tid;
    logic [AW-1:0]   ins_pc;

    logic            ack;
    logic [TIDW-1:0] hzd_t;
    logic [TIDW-1:0] brq_t;
    logic [TIDW-1:0] tid_inc;
    logic [TIDW-1:0] nxt_sel;
    logic [AW-1:0]   nxt_adr;
    logic            nxt_redir;

    assign iwb_stb_o = (state == ST_FETCH);
    assign iwb_adr_o = adr;
    assign ins_dat_o = ins_dat;
    assign ins_vld_o = ins_vld & ena_i;
    assign ins_tid_o = ins_tid;
    assign ins_pc_o  = ins_pc;

    // Per-thread next state. Ordering inside the loop encodes priority:
    // ack update first, then a new redirect overwrites, then a rewind wins.
    always_comb begin
        ack     = (state == ST_FETCH) && iwb_ack_i;
        hzd_t   = (TW == 0) ? '0 : hzd_tid_i;
        brq_t   = (TW == 0) ? '0 : brq_tid_i;
        tid_inc = (TW == 0) ? '0 : tid + TIDW'(1);
        for (int t = 0; t < THREADS; t++) begin
            pc_n[t]   = pc[t];
            pvld_n[t] = pvld[t];
            parm_n[t] = parm[t];
            ptgt_n[t] = ptgt[t];
            if (ack && (TIDW'(t) == tid)) begin
                pc_n[t] = adr + AW'(1);
                if (redir) begin
                    pvld_n[t] = 1'b0;
                    parm_n[t] = 1'b0;
                end else if (pvld[t] && !parm[t]) begin
                    parm_n[t] = 1'b1;
                end
            end
            if (brq_i && (brq_t == TIDW'(t))) begin
                pvld_n[t] = 1'b1;
                parm_n[t] = !brq_dly_i;
                ptgt_n[t] = brq_tgt_i;
            end
            if (hzd_i && (hzd_t == TIDW'(t))) begin
                pc_n[t]   = hzd_pc_i;
                pvld_n[t] = 1'b0;
                parm_n[t] = 1'b0;
            end
        end
    end

    // Address of the fetch that starts next, taken from the updated state so
    // same-cycle redirects and rewinds for the incoming thread are honoured.
    always_comb begin
        nxt_sel   = (state == ST_RST) ? '0 : tid_inc;
        nxt_adr   = pc_n[0];
        nxt_redir = 1'b0;
        for (int t = 0; t < THREADS; t++) begin
            if (TIDW'(t) == nxt_sel) begin
                nxt_adr   = parm_n[t] ? ptgt_n[t] : pc_n[t];
                nxt_redir = parm_n[t];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_RST;
            tid     <= '0;
            adr     <= RST_VEC;
            redir   <= 1'b0;
            ins_dat <= '0;
            ins_vld <= 1'b0;
            ins_tid <= '0;
            ins_pc  <= '0;
            for (int t = 0; t < THREADS; t++) begin
                pc[t]   <= RST_VEC;
                pvld[t] <= 1'b0;
                parm[t] <= 1'b0;
                ptgt[t] <= '0;
            end
        end else if (ena_i) begin
            for (int t = 0; t < THREADS; t++) begin
                pc[t]   <= pc_n[t];
                pvld[t] <= pvld_n[t];
                parm[t] <= parm_n[t];
                ptgt[t] <= ptgt_n[t];
            end
            if (state == ST_RST) begin
                state   <= ST_FETCH;
                tid     <= '0;
                adr     <= nxt_adr;
                redir   <= nxt_redir;
                ins_vld <= 1'b0;
            end else if (ack) begin
                ins_dat <= iwb_dat_i;
                ins_pc  <= adr;
                ins_tid <= tid;
                ins_vld <= 1'b1;
                tid     <= tid_inc;
                adr     <= nxt_adr;
                redir   <= nxt_redir;
            end else begin
                ins_vld <= 1'b0;
                // Wait state: only a rewind of the waiting thread may move the address.
                if (hzd_i && (hzd_t == tid)) begin
                    adr   <= hzd_pc_i;
                    redir <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_aemb3_mt_pcu.sv
// Bench for aemb3_mt_pcu: directed scenarios plus random traffic checked
// against a transaction-level model of thread PCs and pending redirects.
module tb_aemb3_mt_pcu;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        ena_i;
    logic [29:0] iwb_adr_o;
    logic        iwb_stb_o;
    logic        iwb_ack_i;
    logic [31:0] iwb_dat_i;
    logic [31:0] ins_dat_o;
    logic        ins_vld_o;
    logic [0:0]  ins_tid_o;
    logic [29:0] ins_pc_o;
    logic        brq_i;
    logic [0:0]  brq_tid_i;
    logic [29:0] brq_tgt_i;
    logic        brq_dly_i;
    logic        hzd_i;
    logic [0:0]  hzd_tid_i;
    logic [29:0] hzd_pc_i;

    aemb3_mt_pcu #(.IWB(32), .TW(1), .RST_VEC(30'h100)) dut (
        .clk_i(clk), .rst_i(rst_i), .ena_i(ena_i),
        .iwb_adr_o(iwb_adr_o), .iwb_stb_o(iwb_stb_o),
        .iwb_ack_i(iwb_ack_i), .iwb_dat_i(iwb_dat_i),
        .ins_dat_o(ins_dat_o), .ins_vld_o(ins_vld_o),
        .ins_tid_o(ins_tid_o), .ins_pc_o(ins_pc_o),
        .brq_i(brq_i), .brq_tid_i(brq_tid_i), .brq_tgt_i(brq_tgt_i),
        .brq_dly_i(brq_dly_i), .hzd_i(hzd_i), .hzd_tid_i(hzd_tid_i),
        .hzd_pc_i(hzd_pc_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: next sequential PC and pending redirect per thread, active thread.
    logic [29:0] m_pc  [2];
    bit          m_vld [2];
    bit          m_arm [2];
    logic [29:0] m_tgt [2];
    int          m_tid;
    logic [62:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < 2; t++) begin
            m_pc[t] = 30'h100;
            m_vld[t] = 0;
            m_arm[t] = 0;
            m_tgt[t] = '0;
        end
        m_tid = 0;
        exp_q.delete();
    endtask

    // One clock of traffic; called #1 after a rising edge, returns #1 after the next.
    task automatic step(input bit e, input bit ack, input logic [31:0] dat,
                        input bit brq, input int bt, input logic [29:0] tgt, input bit dly,
                        input bit hzd, input int ht, input logic [29:0] hp);
        logic [29:0] a;
        logic [62:0] it;
        int t;
        ena_i = e; iwb_ack_i = ack; iwb_dat_i = dat;
        brq_i = brq; brq_tid_i = 1'(bt); brq_tgt_i = tgt; brq_dly_i = dly;
        hzd_i = hzd; hzd_tid_i = 1'(ht); hzd_pc_i = hp;
        t = m_tid;
        a = m_arm[t] ? m_tgt[t] : m_pc[t];
        chk("stb", 64'(iwb_stb_o), 64'd1);
        chk("adr", 64'(iwb_adr_o), 64'(a));
        if (e) begin
            if (ack) begin
                exp_q.push_back({dat, a, 1'(t)});
                if (m_arm[t]) begin
                    m_pc[t] = m_tgt[t] + 30'd1;
                    m_vld[t] = 0;
                    m_arm[t] = 0;
                end else begin
                    m_pc[t] = m_pc[t] + 30'd1;
                    if (m_vld[t]) m_arm[t] = 1;
                end
                m_tid = (m_tid + 1) % 2;
            end
            if (brq) begin
                m_vld[bt] = 1;
                m_arm[bt] = !dly;
                m_tgt[bt] = tgt;
            end
            if (hzd) begin
                m_pc[ht] = hp;
                m_vld[ht] = 0;
                m_arm[ht] = 0;
            end
        end
        @(posedge clk); #1;
        if (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            chk("vld", 64'(ins_vld_o), 64'd1);
            chk("dat", 64'(ins_dat_o), 64'(it[62:31]));
            chk("pc", 64'(ins_pc_o), 64'(it[30:1]));
            chk("tid", 64'(ins_tid_o), 64'(it[0]));
        end else begin
            chk("novld", 64'(ins_vld_o), 64'd0);
        end
    endtask

    task automatic ack_n(input int n);
        for (int i = 0; i < n; i++) step(1, 1, $urandom, 0, 0, '0, 0, 0, 0, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_stb"}, 64'(iwb_stb_o), 64'd0);
        chk({tag, "_vld"}, 64'(ins_vld_o), 64'd0);
        chk({tag, "_dat"}, 64'(ins_dat_o), 64'd0);
        chk({tag, "_tid"}, 64'(ins_tid_o), 64'd0);
        chk({tag, "_pc"}, 64'(ins_pc_o), 64'd0);
    endtask

    initial begin
        bit prev_ack;
        int guard;
        rst_i = 1; ena_i = 0; iwb_ack_i = 0; iwb_dat_i = '0;
        brq_i = 0; brq_tid_i = '0; brq_tgt_i = '0; brq_dly_i = 0;
        hzd_i = 0; hzd_tid_i = '0; hzd_pc_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");

        // Leaving reset with the enable low must stay idle.
        rst_i = 0;
        @(posedge clk); #1;
        chk("idle_stb", 64'(iwb_stb_o), 64'd0);
        ena_i = 1;
        @(posedge clk); #1;
        model_reset();
        chk("first_adr", 64'(iwb_adr_o), 64'h100);

        // Round robin from the reset vector: 0x100 t0, 0x100 t1, 0x101 t0, 0x101 t1.
        ack_n(4);

        // Rewind t0 to 0x200 while it waits, hold three wait states, then ack.
        step(1, 0, '0, 0, 0, '0, 0, 1, 0, 30'h200);
        repeat (3) step(1, 0, '0, 0, 0, '0, 0, 0, 0, '0);
        ack_n(1);
        chk("wait_pc", 64'(ins_pc_o), 64'h200);

        // t1 at 0x105 redirected to 0x400 without delay slot.
        step(1, 1, $urandom, 0, 0, '0, 0, 1, 1, 30'h105);
        step(1, 1, $urandom, 1, 1, 30'h400, 0, 0, 0, '0);
        ack_n(3);

        // t0 at 0x10A redirected to 0x500 with one delay slot.
        step(1, 1, $urandom, 0, 0, '0, 0, 1, 0, 30'h10A);
        step(1, 1, $urandom, 1, 0, 30'h500, 1, 0, 0, '0);
        ack_n(3);

        // Rewind and redirect of t0 in the same cycle: the rewind wins.
        step(1, 1, $urandom, 1, 0, 30'h600, 0, 1, 0, 30'h0FF);
        ack_n(3);

        // PC increment wraps at the top of the word-address space.
        step(1, 1, $urandom, 0, 0, '0, 0, 1, 1, 30'h3FFFFFFF);
        ack_n(4);

        // Freeze during a wait: ack, redirect and rewind are all ignored.
        step(1, 0, '0, 0, 0, '0, 0, 0, 0, '0);
        step(0, 1, $urandom, 1, 0, 30'h777, 0, 1, 1, 30'h123);
        step(0, 1, $urandom, 0, 0, '0, 0, 0, 0, '0);
        ack_n(4);

        prev_ack = 1;
        for (int i = 0; i < 3000; i++) begin
            bit e, ack, brq, hzd, dly;
            int bt, ht;
            e = ($urandom_range(0, 9) != 0) || prev_ack;
            ack = ($urandom_range(0, 3) != 0);
            brq = ($urandom_range(0, 6) == 0);
            dly = $urandom_range(0, 1) == 1;
            bt = $urandom_range(0, 1);
            if (!ack && bt == m_tid) bt = 1 - m_tid;
            hzd = ($urandom_range(0, 10) == 0);
            ht = $urandom_range(0, 1);
            step(e, ack, $urandom, brq, bt, 30'($urandom), dly, hzd, ht, 30'($urandom));
            prev_ack = e && ack;
        end

        // Reset landing on a t1 wait state together with an ack.
        guard = 0;
        step(1, 0, '0, 0, 0, '0, 0, 0, 0, '0);
        while (m_tid != 1 && guard < 4) begin
            ack_n(1);
            guard++;
        end
        chk("steer_t1", 64'(m_tid), 64'd1);
        step(1, 0, '0, 0, 0, '0, 0, 0, 0, '0);
        rst_i = 1; iwb_ack_i = 1; iwb_dat_i = 32'hDEADBEEF;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rst_i = 0; iwb_ack_i = 0;
        @(posedge clk); #1;
        model_reset();
        chk("restart_tid_vld", 64'(ins_vld_o), 64'd0);
        chk("restart_adr", 64'(iwb_adr_o), 64'h100);
        ack_n(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aemb3_mt_pcu.md
Name: aemb3_mt_pcu

Overview:
- Multi-threaded fetch/programme-counter unit: the parametrised successor of the two-phase branch/PC block.
- Holds one PC per hardware thread and issues instruction-bus fetches round-robin across threads.
- Tolerates bus wait states and latches fetched words with thread tag and PC for the decode stage.
- Applies per-thread branch redirects (with optional delay slot) and hazard rewinds sent back from OF/EX.

Parameters:
- IWB, 32, instruction-bus byte-address width; word address is IWB-1:2.
- TW, 1, thread-ID width; THREADS = 2**TW (TW=0 gives a single thread with tid fixed at 0).
- RST_VEC, 0, word-address reset PC for every thread; IWB-2 bits.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ena_i  in  1  global pipeline enable; 0 freezes all state
- iwb_adr_o  out  IWB-2  fetch word address
- iwb_stb_o  out  1  fetch strobe
- iwb_ack_i  in  1  fetch acknowledge; data is valid in the same cycle
- iwb_dat_i  in  32  fetched instruction
- ins_dat_o  out  32  latched instruction
- ins_vld_o  out  1  ins_* outputs valid this cycle
- ins_tid_o  out  max(TW,1)  thread of the latched instruction
- ins_pc_o  out  IWB-2  word PC of the latched instruction
- brq_i  in  1  branch redirect request
- brq_tid_i  in  max(TW,1)  redirect thread
- brq_tgt_i  in  IWB-2  redirect target
- brq_dly_i  in  1  1 = one delay-slot fetch precedes the target
- hzd_i  in  1  hazard rewind request
- hzd_tid_i  in  max(TW,1)  rewind thread
- hzd_pc_i  in  IWB-2  PC to refetch

Behaviour:
- Reset (rst_i=1 at a clock edge, even mid-transfer):
  - every pc[t] = RST_VEC; tid = 0; all pending redirects cleared.
  - iwb_stb_o = 0, ins_vld_o = 0, ins_dat_o = 0, ins_tid_o = 0, ins_pc_o = 0.
  - An outstanding ack arriving during reset is ignored.
- State machine:
  - RST: entered on reset; moves to FETCH on the first ena_i=1 cycle after reset.
  - FETCH: iwb_stb_o = 1, iwb_adr_o = pc[tid]. Without ack, stay in FETCH holding address and tid (wait state, ins_vld_o = 0). With ack, the instruction completes that cycle.
  - There is no separate WAIT state.
- On ack (registered, visible the next cycle):
  - ins_dat_o = iwb_dat_i, ins_pc_o = pc[tid], ins_tid_o = tid, ins_vld_o = 1.
  - tid advances to (tid+1) mod THREADS.
  - Next pc[tid] is chosen by priority: hazard rewind, then armed redirect, then pc+1.
- ins_vld_o is a single-cycle pulse per acked fetch.
- Latency: address to ins_* valid is 1 cycle after ack.
- PC increment wraps mod 2**(IWB-2).
- Redirect: per-thread pending registers {valid, armed, target}.
  - brq_i with brq_dly_i=0 sets valid and armed.
  - brq_dly_i=1 sets valid only. The next acked fetch of that thread goes sequentially (delay slot) and then sets armed.
  - The next acked fetch with armed set uses the target, and pc[t] becomes target+1.
  - A new brq for a thread already pending overwrites its pending entry.
  - If brq targets the thread being acked in the same cycle, the request applies to that thread's following fetch, not the current one.
- Hazard rewind: hzd_i sets pc[hzd_tid_i] = hzd_pc_i and clears that thread's pending redirect.
  - Takes priority over a same-cycle ack update and a same-cycle brq for the same thread.
  - If hzd_tid_i equals tid during a wait state, iwb_adr_o changes to hzd_pc_i next cycle. This is the only permitted address change while the strobe is held.
- Simultaneous events on different threads are all applied in the same cycle.
- ena_i=0: all registers hold, including pending state. brq_i, hzd_i and iwb_ack_i are ignored; ins_vld_o is forced to 0.
- TW=0: tid is constant 0, and *_tid_i inputs are ignored.

Test Plan:
- Reset then ack every cycle, TW=1, RST_VEC=0x100 -> addresses 0x100(t0), 0x100(t1), 0x101(t0), 0x101(t1); ins_tid_o alternates 0,1.
- Ack withheld 3 cycles on t0 at 0x200 -> iwb_adr_o holds 0x200, ins_vld_o stays 0; on ack, ins_pc_o=0x200 and tid moves to 1.
- brq_i t1, tgt 0x400, dly=0, while t1 pc=0x105 -> next t1 fetch 0x400, following t1 fetch 0x401; t0 sequence unaffected.
- brq t0, tgt 0x500, dly=1, t0 pc=0x10A -> t0 fetches 0x10A then 0x500.
- hzd_i t0 pc 0x0FF in the same cycle as brq t0 tgt 0x600 -> t0 fetches 0x0FF, then 0x100; the redirect is discarded.
- Reset asserted during a t1 wait state with ack in the same cycle -> no ins_vld_o pulse; restart at RST_VEC on t0. Separately, pc 0x3FFFFFFF (IWB=32) increments to 0.
